axis2cells: RTL and testbench

Receive-side converter from AXI-Stream pixels back to packed cell words for the conware computation. It accepts one pixel per beat on an AXIS slave port and classifies each pixel as alive or dead against `alive_color`. It packs WIDTH consecutive pixels into a WIDTH-bit cell word and hands that word to the computation core over a valid/ready handshake. It is the inverse of the cell-to-AXIS pixel streamer and uses the same bit ordering and color convention.

---
 rtl/conware_pkg.sv | 7 +
 rtl/axis2cells_pixel_decode.sv | 10 +
 rtl/axis2cells.sv | 75 +++++++
 tb/tb_axis2cells.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// conware_pkg: shared types and default sizes for the conware cell/pixel converters
package conware_pkg;
  typedef enum logic {FILL, HOLD} state_t;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_WIDTH  = 4;
  localparam int WC_W       = 16;
endpackage

// File: rtl/axis2cells_pixel_decode.sv
// pixel_decode: a pixel is a live cell only on an exact match with alive_color
module pixel_decode #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] pixel,
  input  logic [DWIDTH-1:0] alive_color,
  output logic              alive
);
  assign alive = (pixel == alive_color);
endmodule

// File: rtl/axis2cells.sv
// axis2cells: packs WIDTH AXIS pixels into one cell word, flags short/long packets
module axis2cells
  import conware_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  input  logic [3:0]        S_AXIS_TKEEP,
  input  logic [3:0]        S_AXIS_TSTRB,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              tlast_err,
  output logic [WC_W-1:0]   word_count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [WC_W-1:0] wc_q, wc_d;
  logic rdy_q, rdy_d, err_q, err_d, px, beat, is_last, pend;
  logic unused_side = ^{S_AXIS_TKEEP, S_AXIS_TSTRB};
  pixel_decode #(.DWIDTH(DWIDTH)) u_dec (
    .pixel      (S_AXIS_TDATA),
    .alive_color(alive_color),
    .alive      (px)
  );
  // ready is registered from the next state so it is low while in reset
  always_comb begin
    beat = S_AXIS_TVALID & rdy_q;
    is_last = (cnt_q == LAST);
    pend = beat & (is_last | S_AXIS_TLAST);
    word = shift_q;
    if (beat) word[cnt_q] = px;
    shift_d = pend ? '0 : word;
    cnt_d = pend ? '0 : cnt_q + CW'(beat);
    data_d = pend ? word : data_q;
    err_d = pend & (S_AXIS_TLAST ^ is_last);
    wc_d = wc_q + WC_W'(state_q == HOLD && out_ready);
    state_d = (state_q == FILL) ? (pend ? HOLD : FILL) : (out_ready ? FILL : HOLD);
    rdy_d = (state_d == FILL);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      wc_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      wc_q <= wc_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end
  assign S_AXIS_TREADY = rdy_q;
  assign out_valid = (state_q == HOLD);
  assign out_data = data_q;
  assign tlast_err = err_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_axis2cells.sv
// tb_axis2cells: directed scenarios plus random traffic against a packet-level model
module tb_axis2cells;
  localparam int W = 4;
  localparam logic [31:0] ALIVE = 32'h00FFFFFF;
  localparam logic [31:0] DEAD = 32'h00000000;
  logic clk = 0, rst = 1;
  logic [31:0] tdata = 0;
  logic tvalid = 0, tlast = 0, out_ready = 1;
  logic tready, out_valid, tlast_err;
  logic [W-1:0] out_data;
  logic [15:0] word_count;
  int total = 0, bad = 0;
  bit timeout;

  axis2cells #(.DWIDTH(32), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alive_color(ALIVE),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .S_AXIS_TLAST(tlast), .S_AXIS_TKEEP(4'hF), .S_AXIS_TSTRB(4'hF),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tlast_err(tlast_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: accepted pixels collect in a list; a packet closes on
  // TLAST or the WIDTH-th pixel and becomes a pending word until consumed.
  int bits[$];
  bit m_valid, m_err, fresh;
  int m_word, m_wc;

  always @(negedge clk) begin
    if (rst) begin
      bits.delete();
      m_valid = 0; m_err = 0; m_word = 0; m_wc = 0; fresh = 1;
      chk("rst_tready", tready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_err", tlast_err, 0);
      chk("rst_wc", word_count, 0);
    end else begin
      bit nerr;
      chk("tready", tready, (!m_valid && !fresh) ? 1 : 0);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_word);
      chk("tlast_err", tlast_err, m_err);
      chk("word_count", word_count, m_wc);
      nerr = 0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          m_wc = (m_wc + 1) % 65536;
        end
      end else if (!fresh && tvalid) begin
        bits.push_back(tdata == ALIVE);
        if (tlast || bits.size() == W) begin
          m_word = 0;
          foreach (bits[i]) m_word += bits[i] << i;
          nerr = (tlast != 0) != (bits.size() == W);
          m_valid = 1;
          bits.delete();
        end
      end
      m_err = nerr;
      fresh = 0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send(input logic [31:0] d, input bit last);
    tvalid = 1; tdata = d; tlast = last;
    timeout = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tready) begin timeout = 0; break; end
    end
    if (timeout) chk("send_timeout", 1, 0);
    tick();
    tvalid = 0; tlast = 0;
  endtask

  task automatic expect_word(input string name, input int data, input int err);
    timeout = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin timeout = 0; break; end
    end
    if (timeout) chk({name, "_timeout"}, 1, 0);
    chk({name, "_data"}, out_data, data);
    chk({name, "_err"}, tlast_err, err);
    tick();
  endtask

  int pos;
  initial begin
    repeat (2) tick();
    rst = 0;
    tick();
    // normal packet
    send(ALIVE, 0); send(DEAD, 0); send(ALIVE, 0); send(ALIVE, 1);
    @(negedge clk);
    chk("normal_valid_latency", out_valid, 1);
    chk("normal_data", out_data, 4'b1101);
    chk("normal_tready_low", tready, 0);
    chk("normal_err", tlast_err, 0);
    @(negedge clk);
    chk("normal_valid_one_cycle", out_valid, 0);
    chk("normal_wc", word_count, 1);
    tick();
    // backpressure
    out_ready = 0;
    send(ALIVE, 0); send(ALIVE, 0); send(ALIVE, 0); send(ALIVE, 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_tready", tready, 0);
      chk("bp_data", out_data, 4'b1111);
      chk("bp_valid", out_valid, 1);
    end
    tick();
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_tready_back", tready, 1);
    chk("bp_wc", word_count, 2);
    tick();
    // short packet then normal
    send(ALIVE, 0); send(ALIVE, 1);
    expect_word("short", 4'b0011, 1);
    send(DEAD, 0); send(ALIVE, 0); send(ALIVE, 0); send(DEAD, 1);
    expect_word("after_short", 4'b0110, 0);
    // long packet then a fresh word
    send(DEAD, 0); send(ALIVE, 0); send(DEAD, 0); send(DEAD, 0);
    expect_word("long", 4'b0010, 1);
    send(ALIVE, 0); send(DEAD, 0); send(DEAD, 0); send(ALIVE, 1);
    expect_word("after_long", 4'b1001, 0);
    // unknown colour and TVALID gaps
    send(32'h00123456, 0); repeat (3) tick();
    send(ALIVE, 0); repeat (3) tick();
    send(ALIVE, 0); repeat (3) tick();
    send(ALIVE, 1);
    expect_word("gaps", 4'b1110, 0);
    // reset mid-fill
    send(ALIVE, 0); send(ALIVE, 0);
    rst = 1;
    #1;
    chk("async_tready", tready, 0);
    chk("async_valid", out_valid, 0);
    chk("async_wc", word_count, 0);
    tick(); tick();
    rst = 0;
    tick();
    send(ALIVE, 0); send(DEAD, 0); send(DEAD, 0); send(DEAD, 1);
    expect_word("post_rst", 4'b0001, 0);
    @(negedge clk);
    chk("post_rst_wc", word_count, 1);
    tick();
    // random traffic, checked only by the model
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 2);
      tdata = (r == 0) ? ALIVE : (r == 1) ? DEAD : $urandom;
      tvalid = ($urandom_range(0, 3) != 0);
      tlast = (pos == W - 1);
      if ($urandom_range(0, 9) == 0) tlast = ~tlast;
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (tvalid && tready) pos = (tlast || pos == W - 1) ? 0 : pos + 1;
      tick();
    end
    tvalid = 0;
    out_ready = 1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
